// File: rtl/scan_drv_pkg.sv
// Shared types and constants for the scan chain driver.
package scan_drv_pkg;

    localparam int unsigned CHAIN_LEN_DEF = 7;
    localparam int unsigned CNT_W_DEF     = 4;
    localparam logic [7:0]  FAILCNT_MAX   = 8'd255;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CLR       = 3'd1,
        SHIFT_IN  = 3'd2,
        CAPTURE   = 3'd3,
        SHIFT_OUT = 3'd4,
        CMP       = 3'd5,
        DONE      = 3'd6
    } drv_state_e;

endpackage

// File: rtl/scan_shreg.sv
// Parallel-load, shift-left register with serial-in at bit 0 and serial-out at the MSB.
module scan_shreg #(
    parameter int unsigned WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic             sin,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             sout
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (shift) begin
            q <= {q[WIDTH-2:0], sin};
        end
    end

    assign sout = q[WIDTH-1];

endmodule

// File: rtl/scan_chain_driver.sv
// Tester-side scan master: loads a pattern, fires one capture, unloads and
// compares the response under a mask.
module scan_chain_driver
    import scan_drv_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = CHAIN_LEN_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic                 Clk,
    input  logic                 ClrN,
    input  logic                 Start,
    input  logic                 ClrFirst,
    input  logic [CHAIN_LEN-1:0] PatIn,
    input  logic [CHAIN_LEN-1:0] ExpIn,
    input  logic [CHAIN_LEN-1:0] MaskIn,
    input  logic                 ScanOut,
    output logic                 ScanMode,
    output logic                 ScanIn,
    output logic                 ScanClr,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Fail,
    output logic [CHAIN_LEN-1:0] RespOut,
    output logic [7:0]           FailCnt
);

    drv_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CHAIN_LEN-1:0] exp_q, mask_q;
    logic [CHAIN_LEN-1:0] resp_q;
    logic [CHAIN_LEN-1:0] pat_q_unused;
    logic [CHAIN_LEN-1:0] pat_load_val;
    logic                 resp_sout_unused;
    logic                 pat_sout;
    logic                 accept;
    logic                 last_bit;
    logic                 pat_load, pat_shift, resp_shift;
    logic                 scan_mode_d, scan_in_d, scan_clr_d, busy_d, done_d;
    logic                 cmp_fail;

    assign accept   = (state_q == IDLE) && Start;
    assign last_bit = (cnt_q == CNT_W'(CHAIN_LEN - 1));
    assign cmp_fail = |((resp_q ^ exp_q) & mask_q);

    // Without a clear cycle the first bit goes out straight from PatIn, so the
    // register is loaded pre-shifted to keep its MSB one bit ahead of ScanIn.
    assign pat_load_val = ClrFirst ? PatIn : {PatIn[CHAIN_LEN-2:0], 1'b0};

    scan_shreg #(.WIDTH(CHAIN_LEN)) u_pat (
        .clk   (Clk),
        .rst_n (ClrN),
        .load  (pat_load),
        .shift (pat_shift),
        .sin   (1'b0),
        .d     (pat_load_val),
        .q     (pat_q_unused),
        .sout  (pat_sout)
    );

    scan_shreg #(.WIDTH(CHAIN_LEN)) u_resp (
        .clk   (Clk),
        .rst_n (ClrN),
        .load  (1'b0),
        .shift (resp_shift),
        .sin   (ScanOut),
        .d     ('0),
        .q     (resp_q),
        .sout  (resp_sout_unused)
    );

    // State register
    always_ff @(posedge Clk or negedge ClrN) begin
        if (!ClrN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (Start) state_d = ClrFirst ? CLR : SHIFT_IN;
            CLR:       state_d = SHIFT_IN;
            SHIFT_IN:  if (last_bit) state_d = CAPTURE;
            CAPTURE:   state_d = SHIFT_OUT;
            SHIFT_OUT: if (last_bit) state_d = CMP;
            CMP:       state_d = DONE;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Output and datapath-control decode; outputs follow the state being entered
    always_comb begin
        scan_mode_d = 1'b0;
        scan_in_d   = 1'b0;
        scan_clr_d  = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        pat_load    = accept;
        pat_shift   = (state_q == CLR) || (state_q == SHIFT_IN);
        resp_shift  = (state_q == SHIFT_OUT);
        cnt_d       = cnt_q;

        scan_mode_d = (state_d == SHIFT_IN) || (state_d == SHIFT_OUT);
        scan_clr_d  = (state_d == CLR);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);

        if (state_d == SHIFT_IN) begin
            scan_in_d = (state_q == IDLE) ? PatIn[CHAIN_LEN-1] : pat_sout;
        end

        if ((state_d == SHIFT_IN) || (state_d == SHIFT_OUT)) begin
            cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Registered outputs, compare result and captured operands
    always_ff @(posedge Clk or negedge ClrN) begin
        if (!ClrN) begin
            ScanMode <= 1'b0;
            ScanIn   <= 1'b0;
            ScanClr  <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Fail     <= 1'b0;
            RespOut  <= '0;
            FailCnt  <= '0;
            cnt_q    <= '0;
            exp_q    <= '0;
            mask_q   <= '0;
        end else begin
            ScanMode <= scan_mode_d;
            ScanIn   <= scan_in_d;
            ScanClr  <= scan_clr_d;
            Busy     <= busy_d;
            Done     <= done_d;
            cnt_q    <= cnt_d;
            if (accept) begin
                exp_q  <= ExpIn;
                mask_q <= MaskIn;
            end
            if (state_q == CMP) begin
                Fail    <= cmp_fail;
                RespOut <= resp_q;
                if (cmp_fail && (FailCnt != FAILCNT_MAX)) begin
                    FailCnt <= FailCnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_scan_chain_driver.sv
// Self-checking bench for scan_chain_driver against a behavioural scan-chain DUT model.
`timescale 1ns/1ps
module tb_scan_chain_driver;

    localparam int unsigned L = 7;

    logic         Clk = 1'b0;
    logic         ClrN;
    logic         Start;
    logic         ClrFirst;
    logic [L-1:0] PatIn, ExpIn, MaskIn;
    logic         ScanOut;
    logic         ScanMode, ScanIn, ScanClr, Busy, Done, Fail;
    logic [L-1:0] RespOut;
    logic [7:0]   FailCnt;

    int total = 0;
    int bad   = 0;
    int model_failcnt = 0;

    // Scan-inserted core model: shifts in scan mode, clears on ScanClr,
    // and on a functional clock captures its own contents XOR cap_xor.
    logic [L-1:0] chain   = '0;
    logic [L-1:0] cap_xor = '0;

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (ScanClr)       chain <= '0;
        else if (ScanMode) chain <= {chain[L-2:0], ScanIn};
        else               chain <= chain ^ cap_xor;
    end
    assign ScanOut = chain[L-1];

    scan_chain_driver #(.CHAIN_LEN(L), .CNT_W(4)) dut (
        .Clk      (Clk),
        .ClrN     (ClrN),
        .Start    (Start),
        .ClrFirst (ClrFirst),
        .PatIn    (PatIn),
        .ExpIn    (ExpIn),
        .MaskIn   (MaskIn),
        .ScanOut  (ScanOut),
        .ScanMode (ScanMode),
        .ScanIn   (ScanIn),
        .ScanClr  (ScanClr),
        .Busy     (Busy),
        .Done     (Done),
        .Fail     (Fail),
        .RespOut  (RespOut),
        .FailCnt  (FailCnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, expv);
        end
    endtask

    // One full pattern; want_fail is the expected verdict for this pattern.
    task automatic run_pat(input logic [L-1:0] pat, input logic [L-1:0] expv,
                           input logic [L-1:0] mask, input logic clr,
                           input logic [L-1:0] xr, input bit poke, input logic want_fail);
        logic [L-1:0] ref_resp;
        logic [L-1:0] sin_seq;
        logic [L-1:0] act_resp;
        logic         act_fail;
        logic [7:0]   act_cnt;
        int c, nmode, nclr, clr_cyc, first_mode, done_cyc, both, stray, busy_drop, late;

        ref_resp = pat ^ xr;
        if (want_fail && model_failcnt < 255) model_failcnt++;
        sin_seq = '0; act_resp = '0; act_fail = 1'b0; act_cnt = '0;
        nmode = 0; nclr = 0; clr_cyc = 0; first_mode = 0; done_cyc = 0;
        both = 0; stray = 0; busy_drop = 0; late = 0;

        @(negedge Clk);
        PatIn = pat; ExpIn = expv; MaskIn = mask; ClrFirst = clr; cap_xor = xr; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0; PatIn = L'($urandom); ExpIn = L'($urandom); MaskIn = L'($urandom);
        ClrFirst = 1'b0;

        c = 0;
        while (done_cyc == 0 && c < 40) begin
            if (c > 0) @(negedge Clk);
            c++;
            if (ScanMode && ScanClr) both++;
            if (ScanClr) begin nclr++; clr_cyc = c; end
            if (ScanMode) begin
                if (first_mode == 0) first_mode = c;
                nmode++;
                if (nmode <= L) sin_seq = {sin_seq[L-2:0], ScanIn};
                else if (ScanIn) stray++;
            end else if (ScanIn) begin
                stray++;
            end
            if (!Busy) busy_drop++;
            if (clr && c == 2) check("clr_cleared_chain", 32'(chain), 32'd0);
            if (Done) begin
                done_cyc = c; act_resp = RespOut; act_fail = Fail; act_cnt = FailCnt;
            end
            if (poke) Start = (c == 5) || Done;
        end
        if (done_cyc == 0) check("done_timeout", 32'd0, 32'd1);

        @(negedge Clk);
        Start = 1'b0;
        check("done_width", 32'(Done), 32'd0);
        check("busy_after", 32'(Busy), 32'd0);
        check("done_cycle", 32'(done_cyc), 32'(17 + int'(clr)));
        check("clr_count", 32'(nclr), 32'(clr));
        if (clr) begin
            check("clr_cycle", 32'(clr_cyc), 32'd1);
            check("first_shift_cycle", 32'(first_mode), 32'd2);
        end
        check("clr_mode_overlap", 32'(both), 32'd0);
        check("scanmode_cycles", 32'(nmode), 32'(2 * L));
        check("scanin_seq", 32'(sin_seq), 32'(pat));
        check("scanin_stray", 32'(stray), 32'd0);
        check("busy_drop", 32'(busy_drop), 32'd0);
        check("resp", 32'(act_resp), 32'(ref_resp));
        check("fail", 32'(act_fail), 32'(want_fail));
        check("failcnt", 32'(act_cnt), 32'(model_failcnt));
        check("resp_held", 32'(RespOut), 32'(ref_resp));
        if (poke) begin
            repeat (20) begin
                @(negedge Clk);
                if (Done || Busy) late++;
            end
            check("ignored_start", 32'(late), 32'd0);
        end
    endtask

    typedef struct {
        logic [L-1:0] pat;
        logic [L-1:0] expv;
        logic [L-1:0] mask;
        logic         clr;
        logic [L-1:0] xr;
        bit           poke;
        logic         want_fail;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [L-1:0] p, x, m, e, r;
        logic         cf;
        int           late;

        vecs[0] = '{7'b1011001, 7'b1011001, 7'h7F, 1'b0, 7'h00, 1'b0, 1'b0};
        vecs[1] = '{7'b1011001, 7'b1011000, 7'h7F, 1'b0, 7'h00, 1'b0, 1'b1};
        vecs[2] = '{7'b1011001, 7'b1011000, 7'h7E, 1'b0, 7'h00, 1'b0, 1'b0};
        vecs[3] = '{7'b0110101, 7'b0110101, 7'h7F, 1'b1, 7'h00, 1'b0, 1'b0};
        vecs[4] = '{7'b1100110, 7'b0011001, 7'h7F, 1'b0, 7'h7F, 1'b0, 1'b0};
        vecs[5] = '{7'b0101010, 7'b0000000, 7'h00, 1'b0, 7'h11, 1'b1, 1'b0};
        vecs[6] = '{7'b1111111, 7'b1111111, 7'h40, 1'b1, 7'h40, 1'b0, 1'b1};

        ClrN = 1'b0; Start = 1'b0; ClrFirst = 1'b0;
        PatIn = '0; ExpIn = '0; MaskIn = '0;
        repeat (3) @(negedge Clk);
        check("rst_outputs", 32'({ScanMode, ScanIn, ScanClr, Busy, Done, Fail}), 32'd0);
        check("rst_resp", 32'(RespOut), 32'd0);
        check("rst_failcnt", 32'(FailCnt), 32'd0);
        ClrN = 1'b1;
        repeat (2) @(negedge Clk);
        check("idle_busy", 32'(Busy), 32'd0);

        for (int i = 0; i < 7; i++)
            run_pat(vecs[i].pat, vecs[i].expv, vecs[i].mask, vecs[i].clr,
                    vecs[i].xr, vecs[i].poke, vecs[i].want_fail);

        // Randomised patterns against the verdict rule
        for (int i = 0; i < 24; i++) begin
            p  = L'($urandom);
            x  = ($urandom_range(0, 1) == 0) ? '0 : L'($urandom);
            m  = L'($urandom);
            cf = 1'($urandom);
            r  = p ^ x;
            e  = r ^ (($urandom_range(0, 1) == 0) ? '0 : L'(1 << $urandom_range(0, L - 1)));
            run_pat(p, e, m, cf, x, 1'b0, |((r ^ e) & m));
        end

        // Reset in the third SHIFT_OUT cycle abandons the pattern
        @(negedge Clk);
        PatIn = 7'b1010101; ExpIn = 7'h00; MaskIn = 7'h7F; ClrFirst = 1'b0; cap_xor = '0; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (10) @(negedge Clk);
        check("pre_rst_mode", 32'(ScanMode), 32'd1);
        check("pre_rst_failcnt_nz", 32'(FailCnt != 8'd0), 32'd1);
        ClrN = 1'b0;
        #1;
        check("async_rst_outputs", 32'({ScanMode, ScanIn, ScanClr, Busy, Done, Fail}), 32'd0);
        check("async_rst_resp", 32'(RespOut), 32'd0);
        check("async_rst_failcnt", 32'(FailCnt), 32'd0);
        model_failcnt = 0;
        repeat (3) @(negedge Clk);
        ClrN = 1'b1;
        late = 0;
        repeat (20) begin
            @(negedge Clk);
            if (Done || Busy) late++;
        end
        check("no_done_after_rst", 32'(late), 32'd0);
        run_pat(7'b1011001, 7'b1011001, 7'h7F, 1'b0, 7'h00, 1'b0, 1'b0);

        // Saturation of the failing-pattern counter
        for (int i = 0; i < 260; i++) begin
            p = L'($urandom);
            run_pat(p, p ^ 7'h01, 7'h7F, 1'b0, 7'h00, 1'b0, 1'b1);
        end
        check("failcnt_saturated", 32'(FailCnt), 32'd255);
        run_pat(7'b0001111, 7'b0001111, 7'h7F, 1'b1, 7'h00, 1'b0, 1'b0);
        check("failcnt_hold", 32'(FailCnt), 32'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scan_chain_driver.md
Name: scan_chain_driver

Overview:
- Tester-side master for a single scan chain: serially loads a test pattern into the DUT chain through ScanIn, then fires one capture clock with ScanMode low.
- Unloads the captured response from ScanOut and compares it against an expected vector under a mask.
- Sits between a pattern source (bench, BIST sequencer or JTAG-style bridge) and any scan-inserted core with ports ScanMode/ScanIn/ScanOut/ScanClr on the same clock.

Parameters:
- CHAIN_LEN, 7, number of flip-flops in the DUT scan chain (≥2).
- CNT_W, 4, bit-counter width; must satisfy 2**CNT_W > CHAIN_LEN.

Ports:
- Clk  input  1  block clock; also the DUT scan clock; all logic on rising edge.
- ClrN  input  1  reset; asynchronous, active-low.
- Start  input  1  request one pattern; accepted only in IDLE.
- ClrFirst  input  1  sampled with Start; 1 = pulse ScanClr before shifting.
- PatIn  input  CHAIN_LEN  stimulus vector; captured at Start.
- ExpIn  input  CHAIN_LEN  expected response; captured at Start.
- MaskIn  input  CHAIN_LEN  1 = compare bit; captured at Start.
- ScanOut  input  1  serial data from the end of the DUT chain.
- ScanMode  output  1  1 = DUT chain in shift mode.
- ScanIn  output  1  serial data into the head of the DUT chain.
- ScanClr  output  1  active-high clear to the DUT flip-flops.
- Busy  output  1  high in every state except IDLE.
- Done  output  1  one-cycle pulse when the result is valid.
- Fail  output  1  result of the last compare; held until the next Done.
- RespOut  output  CHAIN_LEN  last unloaded response; held until the next Done.
- FailCnt  output  8  saturating count of failing patterns.

Behaviour:
- Reset (ClrN=0, asynchronous): state=IDLE; all registered outputs cleared.
  - ScanMode=0, ScanIn=0, ScanClr=0, Busy=0, Done=0, Fail=0, RespOut=0, FailCnt=0.
  - Internal pattern, expected, mask and response registers cleared.
  - Reset mid-operation abandons the pattern with no Done; DUT chain contents are don't-care.
- All outputs are registered, with no combinational path from input to output.
- State machine:
  - IDLE: on Start=1, latch PatIn/ExpIn/MaskIn/ClrFirst; go to CLR if ClrFirst=1, else SHIFT_IN. Start=0 keeps IDLE.
  - CLR: exactly 1 cycle with ScanClr=1 and ScanMode=0, then SHIFT_IN.
  - SHIFT_IN: exactly CHAIN_LEN cycles with ScanMode=1. ScanIn carries PatIn MSB first: cycle i (0-based) drives PatIn[CHAIN_LEN-1-i]. Then CAPTURE.
  - CAPTURE: exactly 1 cycle with ScanMode=0 and ScanIn=0; the DUT captures functional data. Then SHIFT_OUT.
  - SHIFT_OUT: exactly CHAIN_LEN cycles with ScanMode=1 and ScanIn=0. ScanOut is sampled at each rising edge that ends a cycle; the response register shifts left, inserting ScanOut at bit 0. The first sample ends in bit CHAIN_LEN-1. Then CMP.
  - CMP: 1 cycle. Fail_next = |((resp ^ exp) & mask). RespOut is updated. Done pulses 1 in the following cycle (DONE state), then IDLE.
  - DONE: Done=1, Busy=1, 1 cycle, then IDLE.
- Latency: Start accepted at edge 0; Done high in cycle 2*CHAIN_LEN+3 (+1 if ClrFirst). Default, ClrFirst=0: cycle 17.
- Start while Busy=1, including the DONE cycle, is ignored; no queueing.
- Bit counter counts 0..CHAIN_LEN-1 and reloads 0 on each SHIFT state entry. The SHIFT_IN exit and SHIFT_OUT exit coincide with the counter reaching CHAIN_LEN-1.
- FailCnt increments on a failing CMP and saturates at 255 (no wrap). It is cleared only by reset.
- MaskIn=0 forces Fail=0 regardless of response.
- ScanClr and ScanMode are never both 1.

Decomposition:
- Package scan_drv_pkg holds:
  - The state enum: IDLE, CLR, SHIFT_IN, CAPTURE, SHIFT_OUT, CMP, DONE.
  - Constant FAILCNT_MAX=8'd255.
  - Default CHAIN_LEN.
- Sub-module scan_shreg: CHAIN_LEN-bit register with parallel load, shift-left enable, serial-in bit 0 and serial-out MSB. Instantiate it twice, once for the pattern and once for the response.

Test Plan:
- DUT modelled as a 7-bit shift register that holds its value on capture; PatIn=7'b1011001, ExpIn=PatIn, MaskIn=7'h7F -> ScanIn sequence 1,0,1,1,0,0,1; RespOut=7'b1011001, Fail=0, Done in cycle 17.
- Same model, ExpIn=7'b1011000, MaskIn=7'h7F -> Fail=1, FailCnt=1. Rerun with MaskIn=7'h7E -> Fail=0, FailCnt stays 1.
- ClrFirst=1 with a model clearing on ScanClr -> ScanClr high for exactly 1 cycle before the first ScanMode=1 cycle; Done in cycle 18.
- Start pulsed at cycle 5 and again during the DONE cycle -> both ignored; exactly one Done per accepted Start.
- ClrN driven low during SHIFT_OUT cycle 3 -> all outputs 0 asynchronously, with no Done. After release, a new Start completes normally.
- 260 consecutive failing patterns -> FailCnt reads 255 and stays at 255.
